haar_cascade_sequencer: RTL and testbench

//  Sequences Viola-Jones cascade evaluation for one 20x20 detection window.

---
 rtl/haar_pkg.sv | 54 +++++
 rtl/haar_rect_sum.sv | 44 ++++
 rtl/haar_cascade_sequencer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_haar_cascade_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haar_pkg.sv
// haar_pkg: shared types and constants for the Haar cascade sequencer.
//   haar_rect_t  : one weighted rectangle {x, y, w, h, weight(signed 3b)}
//   haar_feat_t  : three rectangles (rects[0] evaluated first), threshold, left/right votes
//   haar_stage_t : {feat_count[7:0], stage_thresh}
//   haar_state_t : controller FSM state encoding
package haar_pkg;

    localparam int NUM_STAGES = 22;
    localparam int WIN_SIZE   = 20;
    localparam int ACC_W      = 32;
    localparam int II_W       = 32;

    typedef struct packed {
        logic [4:0]        x;
        logic [4:0]        y;
        logic [4:0]        w;
        logic [4:0]        h;
        logic signed [2:0] weight;
    } haar_rect_t;

    typedef struct packed {
        haar_rect_t [2:0]        rects;
        logic signed [ACC_W-1:0] feat_thresh;
        logic signed [ACC_W-1:0] left_val;
        logic signed [ACC_W-1:0] right_val;
    } haar_feat_t;

    typedef struct packed {
        logic [7:0]              feat_count;
        logic signed [ACC_W-1:0] stage_thresh;
    } haar_stage_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STG_LD,
        ST_FEAT_LD,
        ST_CORNER,
        ST_RECT_ACC,
        ST_FEAT_CMP,
        ST_STG_CMP,
        ST_DONE
    } haar_state_t;

    // Absolute corner coordinate: origin + rect offset + optional extent, 6-bit wrap.
    function automatic logic [5:0] corner_coord(input logic [4:0] origin,
                                                input logic [4:0] offset,
                                                input logic [4:0] extent,
                                                input logic       use_extent);
        logic [5:0] ext6;
        ext6 = use_extent ? {1'b0, extent} : 6'd0;
        return {1'b0, origin} + {1'b0, offset} + ext6;
    endfunction

endpackage

// File: rtl/haar_rect_sum.sv
// haar_rect_sum: four-corner integral-image accumulator for one rectangle.
//   Computes A - B - C + D as corners arrive (corner index 0..3 = A,B,C,D).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      zero the running sum (start of a rectangle)
//   valid_in   accept sample for the given corner this cycle
//   corner     corner index of sample (0=A, 1=B, 2=C, 3=D)
//   sample     unsigned integral-image value
//   sum        signed running rectangle sum (wraps at ACC_W bits)
module haar_rect_sum
    import haar_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    valid_in,
    input  logic [1:0]              corner,
    input  logic [II_W-1:0]         sample,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] sum_reg;
    logic signed [ACC_W-1:0] sample_ext;

    assign sample_ext = ACC_W'(sample);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= '0;
        end else if (valid_in) begin
            // A and D add, B and C subtract.
            if (corner == 2'd0 || corner == 2'd3) begin
                sum_reg <= sum_reg + sample_ext;
            end else begin
                sum_reg <= sum_reg - sample_ext;
            end
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/haar_cascade_sequencer.sv
// haar_cascade_sequencer: walks the stage/feature ROMs for one 20x20 window,
// fetches four integral-image corners per rectangle and produces a face verdict.
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   START, win_x, win_y   start request (accepted only in IDLE) and window origin
//   stg_addr/stg_data     stage ROM (1-cycle read latency)
//   feat_addr/feat_data   feature ROM (1-cycle read latency)
//   ii_req/ii_x/ii_y      integral read request and absolute corner coordinate
//   ii_gnt/ii_data        grant with same-cycle data
//   busy, done            evaluation in progress / 1-cycle completion pulse
//   is_face, fail_stage   verdict and failing stage (NUM_STAGES when passed)
// Optional build macro HAAR_PERF_CNT_EN adds perf_cycles[15:0] (busy cycles)
// and perf_feats[11:0] (completed feature compares); both saturate.
module haar_cascade_sequencer
    import haar_pkg::*;
#(
    parameter int NUM_STAGES = haar_pkg::NUM_STAGES,
    parameter int FEAT_AW    = 13
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            START,
    input  logic [4:0]                      win_x,
    input  logic [4:0]                      win_y,
    output logic [4:0]                      stg_addr,
    input  logic [$bits(haar_stage_t)-1:0]  stg_data,
    output logic [FEAT_AW-1:0]              feat_addr,
    input  logic [$bits(haar_feat_t)-1:0]   feat_data,
    output logic                            ii_req,
    output logic [5:0]                      ii_x,
    output logic [5:0]                      ii_y,
    input  logic                            ii_gnt,
    input  logic [II_W-1:0]                 ii_data,
    output logic                            busy,
    output logic                            done,
    output logic                            is_face,
    output logic [4:0]                      fail_stage
`ifdef HAAR_PERF_CNT_EN
    ,
    output logic [15:0]                     perf_cycles,
    output logic [11:0]                     perf_feats
`endif
);

    localparam logic [4:0] LAST_STAGE = 5'(NUM_STAGES - 1);
    localparam logic [4:0] PASS_CODE  = 5'(NUM_STAGES);

    haar_state_t             state_reg, state_next;
    logic                    phase_reg, phase_next;   // 0: address presented, 1: ROM data valid
    logic [4:0]              stage_reg, stage_next;
    logic [FEAT_AW-1:0]      feat_addr_reg, feat_addr_next;
    logic [4:0]              win_x_reg, win_x_next;
    logic [4:0]              win_y_reg, win_y_next;
    logic [7:0]              feat_rem_reg, feat_rem_next;
    logic signed [ACC_W-1:0] stage_thresh_reg, stage_thresh_next;
    haar_feat_t              feat_reg, feat_next;
    logic signed [ACC_W-1:0] feat_sum_reg, feat_sum_next;
    logic signed [ACC_W-1:0] stage_acc_reg, stage_acc_next;
    logic [1:0]              rect_idx_reg, rect_idx_next;
    logic [1:0]              corner_reg, corner_next;
    logic                    is_face_reg, is_face_next;
    logic [4:0]              fail_stage_reg, fail_stage_next;

    logic                    rs_clear, rs_valid;
    logic signed [ACC_W-1:0] rect_sum;
    haar_stage_t             stg_in;
    haar_feat_t              feat_in;
    haar_rect_t              cur_rect;
    logic [2:0]              rect_live;   // rect has non-zero w and h
    logic [2:0]              rect_w_nz;   // rect has non-zero w (terminates the list when zero)
    logic                    next_rect_ok;
    logic signed [ACC_W-1:0] weight_ext, weighted, vote;

    assign stg_in  = haar_stage_t'(stg_data);
    assign feat_in = haar_feat_t'(feat_data);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rect
            assign rect_w_nz[gi] = (feat_reg.rects[gi].w != 5'd0);
            assign rect_live[gi] = rect_w_nz[gi] && (feat_reg.rects[gi].h != 5'd0);
        end
    endgenerate

    always_comb begin
        case (rect_idx_reg)
            2'd0:    cur_rect = feat_reg.rects[0];
            2'd1:    cur_rect = feat_reg.rects[1];
            default: cur_rect = feat_reg.rects[2];
        endcase
    end

    assign next_rect_ok = (rect_idx_reg == 2'd0) ? rect_w_nz[1] :
                          (rect_idx_reg == 2'd1) ? rect_w_nz[2] : 1'b0;

    assign weight_ext = {{(ACC_W-3){cur_rect.weight[2]}}, cur_rect.weight};
    assign weighted   = weight_ext * rect_sum;
    assign vote       = (feat_sum_reg < feat_reg.feat_thresh) ? feat_reg.left_val
                                                              : feat_reg.right_val;

    haar_rect_sum u_rect_sum (
        .clk      (Clk),
        .rst      (Reset),
        .clear    (rs_clear),
        .valid_in (rs_valid),
        .corner   (corner_reg),
        .sample   (ii_data),
        .sum      (rect_sum)
    );

    always_comb begin
        state_next        = state_reg;
        phase_next        = phase_reg;
        stage_next        = stage_reg;
        feat_addr_next    = feat_addr_reg;
        win_x_next        = win_x_reg;
        win_y_next        = win_y_reg;
        feat_rem_next     = feat_rem_reg;
        stage_thresh_next = stage_thresh_reg;
        feat_next         = feat_reg;
        feat_sum_next     = feat_sum_reg;
        stage_acc_next    = stage_acc_reg;
        rect_idx_next     = rect_idx_reg;
        corner_next       = corner_reg;
        is_face_next      = is_face_reg;
        fail_stage_next   = fail_stage_reg;
        rs_clear          = 1'b0;
        rs_valid          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    win_x_next      = win_x;
                    win_y_next      = win_y;
                    stage_acc_next  = '0;
                    stage_next      = '0;
                    feat_addr_next  = '0;
                    is_face_next    = 1'b0;
                    fail_stage_next = '0;
                    phase_next      = 1'b0;
                    state_next      = ST_STG_LD;
                end
            end
            ST_STG_LD: begin
                if (!phase_reg) begin
                    phase_next = 1'b1;
                end else begin
                    phase_next        = 1'b0;
                    feat_rem_next     = stg_in.feat_count;
                    stage_thresh_next = stg_in.stage_thresh;
                    state_next        = (stg_in.feat_count == 8'd0) ? ST_STG_CMP : ST_FEAT_LD;
                end
            end
            ST_FEAT_LD: begin
                if (!phase_reg) begin
                    phase_next = 1'b1;
                end else begin
                    phase_next    = 1'b0;
                    feat_next     = feat_in;
                    feat_sum_next = '0;
                    rect_idx_next = '0;
                    corner_next   = '0;
                    rs_clear      = 1'b1;
                    state_next    = ST_CORNER;
                end
            end
            ST_CORNER: begin
                // Degenerate rectangles fall through with a zero sum and no reads.
                if (!rect_live[rect_idx_reg]) begin
                    state_next = ST_RECT_ACC;
                end else if (ii_gnt) begin
                    rs_valid    = 1'b1;
                    corner_next = corner_reg + 2'd1;
                    if (corner_reg == 2'd3) begin
                        state_next = ST_RECT_ACC;
                    end
                end
            end
            ST_RECT_ACC: begin
                feat_sum_next = feat_sum_reg + weighted;
                if (next_rect_ok) begin
                    rect_idx_next = rect_idx_reg + 2'd1;
                    corner_next   = '0;
                    rs_clear      = 1'b1;
                    state_next    = ST_CORNER;
                end else begin
                    state_next = ST_FEAT_CMP;
                end
            end
            ST_FEAT_CMP: begin
                stage_acc_next = stage_acc_reg + vote;
                feat_addr_next = feat_addr_reg + 1'b1;
                feat_rem_next  = feat_rem_reg - 8'd1;
                state_next     = (feat_rem_reg == 8'd1) ? ST_STG_CMP : ST_FEAT_LD;
            end
            ST_STG_CMP: begin
                if (stage_acc_reg < stage_thresh_reg) begin
                    is_face_next    = 1'b0;
                    fail_stage_next = stage_reg;
                    state_next      = ST_DONE;
                end else if (stage_reg == LAST_STAGE) begin
                    is_face_next    = 1'b1;
                    fail_stage_next = PASS_CODE;
                    state_next      = ST_DONE;
                end else begin
                    // Feature address keeps running: features are stored back to back.
                    stage_next     = stage_reg + 5'd1;
                    stage_acc_next = '0;
                    phase_next     = 1'b0;
                    state_next     = ST_STG_LD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg        <= ST_IDLE;
            phase_reg        <= 1'b0;
            stage_reg        <= '0;
            feat_addr_reg    <= '0;
            win_x_reg        <= '0;
            win_y_reg        <= '0;
            feat_rem_reg     <= '0;
            stage_thresh_reg <= '0;
            feat_reg         <= '0;
            feat_sum_reg     <= '0;
            stage_acc_reg    <= '0;
            rect_idx_reg     <= '0;
            corner_reg       <= '0;
            is_face_reg      <= 1'b0;
            fail_stage_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            stage_reg        <= stage_next;
            feat_addr_reg    <= feat_addr_next;
            win_x_reg        <= win_x_next;
            win_y_reg        <= win_y_next;
            feat_rem_reg     <= feat_rem_next;
            stage_thresh_reg <= stage_thresh_next;
            feat_reg         <= feat_next;
            feat_sum_reg     <= feat_sum_next;
            stage_acc_reg    <= stage_acc_next;
            rect_idx_reg     <= rect_idx_next;
            corner_reg       <= corner_next;
            is_face_reg      <= is_face_next;
            fail_stage_reg   <= fail_stage_next;
        end
    end

    assign stg_addr   = stage_reg;
    assign feat_addr  = feat_addr_reg;
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done       = (state_reg == ST_DONE);
    assign is_face    = is_face_reg;
    assign fail_stage = fail_stage_reg;
    // Coordinates depend only on registers, so they stay put while waiting for a grant.
    assign ii_req     = (state_reg == ST_CORNER) && rect_live[rect_idx_reg];
    assign ii_x       = corner_coord(win_x_reg, cur_rect.x, cur_rect.w, corner_reg[0]);
    assign ii_y       = corner_coord(win_y_reg, cur_rect.y, cur_rect.h, corner_reg[1]);

`ifdef HAAR_PERF_CNT_EN
    logic [15:0] perf_cycles_reg;
    logic [11:0] perf_feats_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            perf_cycles_reg <= '0;
            perf_feats_reg  <= '0;
        end else if (state_reg == ST_IDLE && START) begin
            perf_cycles_reg <= '0;
            perf_feats_reg  <= '0;
        end else begin
            if (busy && !(&perf_cycles_reg)) begin
                perf_cycles_reg <= perf_cycles_reg + 16'd1;
            end
            if (state_reg == ST_FEAT_CMP && !(&perf_feats_reg)) begin
                perf_feats_reg <= perf_feats_reg + 12'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_feats  = perf_feats_reg;
`endif

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Testbench for haar_cascade_sequencer: table of single-feature vectors plus
// hand-written sequences (reset mid-read, multi-stage cascades).
module tb_haar_cascade_sequencer;
    import haar_pkg::*;

    localparam int NSTG = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        START = 1'b0;
    logic [4:0]  win_x = '0;
    logic [4:0]  win_y = '0;
    logic [4:0]  stg_addr;
    logic [$bits(haar_stage_t)-1:0] stg_data;
    logic [12:0] feat_addr;
    logic [$bits(haar_feat_t)-1:0]  feat_data;
    logic        ii_req;
    logic [5:0]  ii_x, ii_y;
    logic        ii_gnt = 1'b0;
    logic [31:0] ii_data;
    logic        busy, done, is_face;
    logic [4:0]  fail_stage;

    haar_stage_t stg_rom  [32];
    haar_feat_t  feat_rom [8192];
    logic [31:0] ii_mem   [4096];

    int errors = 0;
    int checks = 0;

    // Counters written only by the bus monitor below.
    int reads = 0;
    int done_cnt = 0;
    int stab_err = 0;
    int stg2_seen = 0;
    int wait_left = 0;
    logic       pend = 1'b0;
    logic [5:0] px = '0, py = '0;

    // Written only by the stimulus process.
    int   dmax = 0;
    logic gnt_block = 1'b0;

    always #5 Clk = ~Clk;

    haar_cascade_sequencer #(.NUM_STAGES(NSTG), .FEAT_AW(13)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .START      (START),
        .win_x      (win_x),
        .win_y      (win_y),
        .stg_addr   (stg_addr),
        .stg_data   (stg_data),
        .feat_addr  (feat_addr),
        .feat_data  (feat_data),
        .ii_req     (ii_req),
        .ii_x       (ii_x),
        .ii_y       (ii_y),
        .ii_gnt     (ii_gnt),
        .ii_data    (ii_data),
        .busy       (busy),
        .done       (done),
        .is_face    (is_face),
        .fail_stage (fail_stage)
    );

    always @(posedge Clk) begin
        stg_data  <= stg_rom[stg_addr];
        feat_data <= feat_rom[feat_addr];
    end

    assign ii_data = ii_mem[{ii_y, ii_x}];

    // Integral-buffer model: grants after a random wait, checks request stability.
    always @(negedge Clk) begin
        if (done) done_cnt++;
        if (busy && stg_addr == 5'd2) stg2_seen++;
        if (ii_req) begin
            if (pend && (ii_x != px || ii_y != py)) stab_err++;
            if (!gnt_block && wait_left == 0) begin
                ii_gnt = 1'b1;
                reads++;
                pend = 1'b0;
                wait_left = int'($urandom_range(32'(dmax), 0));
            end else begin
                ii_gnt = 1'b0;
                if (!gnt_block && wait_left > 0) wait_left--;
                pend = 1'b1;
                px = ii_x;
                py = ii_y;
            end
        end else begin
            ii_gnt = 1'b0;
            pend = 1'b0;
        end
    end

    typedef struct {
        int         wx, wy;
        haar_rect_t r0;
        int         c0 [4];   // A, B, C, D
        haar_rect_t r1;
        int         c1 [4];
        int         fth, lv, rv, sth;
        int         dly;
        int         restart;
        int         exp_face, exp_fail, exp_reads;
    } vec_t;

    vec_t vecs [8];

    function automatic haar_rect_t mk_rect(input int x, y, w, h, wt);
        haar_rect_t r;
        r.x = 5'(x); r.y = 5'(y); r.w = 5'(w); r.h = 5'(h); r.weight = 3'(wt);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic place(input int wx, wy, input haar_rect_t r, input int c [4]);
        int ax, ay;
        if (r.w == 0 || r.h == 0) return;
        ax = wx + int'(r.x);
        ay = wy + int'(r.y);
        ii_mem[ay*64 + ax]                       = 32'(c[0]);
        ii_mem[ay*64 + ax + int'(r.w)]           = 32'(c[1]);
        ii_mem[(ay+int'(r.h))*64 + ax]           = 32'(c[2]);
        ii_mem[(ay+int'(r.h))*64 + ax + int'(r.w)] = 32'(c[3]);
    endtask

    task automatic load_vec(input vec_t v);
        haar_feat_t f;
        stg_rom[0].feat_count = 8'd1;  stg_rom[0].stage_thresh = v.sth;
        stg_rom[1].feat_count = 8'd0;  stg_rom[1].stage_thresh = 0;
        stg_rom[2].feat_count = 8'd0;  stg_rom[2].stage_thresh = 0;
        f.rects[0] = v.r0;
        f.rects[1] = v.r1;
        f.rects[2] = '0;
        f.feat_thresh = v.fth;
        f.left_val = v.lv;
        f.right_val = v.rv;
        feat_rom[0] = f;
        place(v.wx, v.wy, v.r0, v.c0);
        place(v.wx, v.wy, v.r1, v.c1);
        dmax = v.dly;
    endtask

    task automatic pulse_start(input int wx, wy);
        @(negedge Clk);
        win_x = 5'(wx);
        win_y = 5'(wy);
        START = 1'b1;
        @(negedge Clk);
        START = 1'b0;
    endtask

    // Waits for done (bounded), then settles into IDLE.
    task automatic wait_done(input string nm, input int d0);
        int n;
        for (n = 0; n < 1000 && done_cnt == d0; n++) @(negedge Clk);
        chk({nm, " done_seen"}, 64'(done_cnt != d0), 1);
        repeat (4) @(negedge Clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int r0, d0, s0;
        string nm;
        nm = $sformatf("v%0d", idx);
        load_vec(v);
        r0 = reads; d0 = done_cnt; s0 = stab_err;
        pulse_start(v.wx, v.wy);
        chk({nm, " busy"}, 64'(busy), 1);
        if (v.restart != 0) begin
            repeat (5) @(negedge Clk);
            win_x = 5'd9; win_y = 5'd9; START = 1'b1;
            @(negedge Clk);
            START = 1'b0;
        end
        wait_done(nm, d0);
        chk({nm, " is_face"}, 64'(is_face), 64'(v.exp_face));
        chk({nm, " fail_stage"}, 64'(fail_stage), 64'(v.exp_fail));
        chk({nm, " reads"}, 64'(reads - r0), 64'(v.exp_reads));
        chk({nm, " done_pulses"}, 64'(done_cnt - d0), 1);
        chk({nm, " stable"}, 64'(stab_err - s0), 0);
        chk({nm, " idle"}, 64'({busy, done}), 0);
        $display("vec %0d: is_face=%0d fail_stage=%0d reads=%0d", idx, is_face, fail_stage, reads - r0);
    endtask

    task automatic run_cascade(input int thresh1, input int exp_face, exp_fail,
                               exp_reads, exp_faddr, input string nm);
        haar_feat_t f;
        int r0, d0, g0;
        ii_mem[0] = 0; ii_mem[1] = 0; ii_mem[64] = 0; ii_mem[65] = 1;  // rect sum = 1
        f.rects[0] = mk_rect(0, 0, 1, 1, 1);
        f.rects[1] = '0;
        f.rects[2] = '0;
        f.feat_thresh = 0;   // 1 < 0 is false -> right vote
        f.left_val = -9;
        f.right_val = 3;  feat_rom[0] = f;
        f.right_val = 2;  feat_rom[1] = f;
        f.right_val = 4;  feat_rom[2] = f;
        f.right_val = 4;  feat_rom[3] = f;
        stg_rom[0].feat_count = 8'd2; stg_rom[0].stage_thresh = 0;        // acc 5
        stg_rom[1].feat_count = 8'd1; stg_rom[1].stage_thresh = thresh1;  // acc 4
        stg_rom[2].feat_count = 8'd1; stg_rom[2].stage_thresh = 0;        // acc 4
        dmax = 1;
        r0 = reads; d0 = done_cnt; g0 = stg2_seen;
        pulse_start(0, 0);
        wait_done(nm, d0);
        chk({nm, " is_face"}, 64'(is_face), 64'(exp_face));
        chk({nm, " fail_stage"}, 64'(fail_stage), 64'(exp_fail));
        chk({nm, " reads"}, 64'(reads - r0), 64'(exp_reads));
        chk({nm, " feat_addr"}, 64'(feat_addr), 64'(exp_faddr));
        chk({nm, " stg2_addressed"}, 64'(stg2_seen != g0), 64'(exp_face));
        chk({nm, " done_pulses"}, 64'(done_cnt - d0), 1);
        $display("%s: is_face=%0d fail_stage=%0d reads=%0d feat_addr=%0d",
                 nm, is_face, fail_stage, reads - r0, feat_addr);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4096; i++) ii_mem[i] = '0;
        for (int i = 0; i < 32; i++) stg_rom[i] = '0;
        for (int i = 0; i < 8192; i++) feat_rom[i] = '0;

        //        wx wy  r0                     c0 A,B,C,D          r1                      c1               fth  lv  rv  sth  dly rst face fail reads
        vecs[0] = '{0, 0, mk_rect(0,0,2,2, 1), '{0,0,0,10},        mk_rect(0,0,0,0,0),    '{0,0,0,0},       5,  -3,  4,  3,  0,  0,  1, 3, 4};
        vecs[1] = '{0, 0, mk_rect(0,0,2,2, 1), '{0,0,0,2},         mk_rect(0,0,0,0,0),    '{0,0,0,0},       5,  -3,  4,  3,  0,  0,  0, 0, 4};
        vecs[2] = '{0, 0, mk_rect(0,0,2,2, 1), '{0,0,0,10},        mk_rect(0,0,0,0,0),    '{0,0,0,0},       5,  -3,  4,  3,  5,  0,  1, 3, 4};
        vecs[3] = '{1, 1, mk_rect(0,0,2,2, 1), '{5,7,9,20},        mk_rect(4,0,3,1,-2),   '{1,4,2,11},      0,   7, -1,  5,  2,  1,  1, 3, 8};
        vecs[4] = '{0, 0, mk_rect(2,3,4,5,-1), '{10,3,4,50},       mk_rect(0,0,0,0,0),    '{0,0,0,0},     -50,   2, -7,  2,  1,  0,  1, 3, 4};
        vecs[5] = '{0, 0, mk_rect(0,0,3,0, 1), '{0,0,0,0},         mk_rect(1,1,1,1, 2),   '{2,3,4,9},       8,   1, -5, -5,  3,  0,  1, 3, 4};
        vecs[6] = '{1, 1, mk_rect(0,0,2,2, 1), '{5,7,9,20},        mk_rect(4,0,3,1,-2),   '{1,4,2,11},      0,   7, -1,  5,  0,  0,  1, 3, 8};
        vecs[7] = '{0, 0, mk_rect(0,0,2,2, 1), '{0,0,0,4},         mk_rect(0,0,0,0,0),    '{0,0,0,0},       5,  -3,  4,  3,  4,  0,  0, 0, 4};

        // Reset state
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst busy", 64'(busy), 0);
        chk("rst done", 64'(done), 0);
        chk("rst is_face", 64'(is_face), 0);
        chk("rst ii_req", 64'(ii_req), 0);
        chk("rst fail_stage", 64'(fail_stage), 0);
        chk("rst stg_addr", 64'(stg_addr), 0);
        chk("rst feat_addr", 64'(feat_addr), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Reset while a corner read is pending
        gnt_block = 1'b1;
        load_vec(vecs[0]);
        d0 = done_cnt;
        pulse_start(0, 0);
        for (int n = 0; n < 50 && !ii_req; n++) @(negedge Clk);
        chk("midrst ii_req_seen", 64'(ii_req), 1);
        Reset = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 0);
        chk("midrst ii_req", 64'(ii_req), 0);
        @(negedge Clk);
        Reset = 1'b0;
        gnt_block = 1'b0;
        repeat (20) @(negedge Clk);
        chk("midrst no_done", 64'(done_cnt - d0), 0);
        chk("midrst is_face", 64'(is_face), 0);
        chk("midrst busy_after", 64'(busy), 0);
        $display("midrst: busy=%0d ii_req=%0d done_pulses=%0d", busy, ii_req, done_cnt - d0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        run_cascade(10, 0, 1, 12, 3, "casc_fail1");
        run_cascade(4, 1, NSTG, 16, 4, "casc_pass");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
